// File: rtl/fir_xifu_seq.sv
// FIR instruction sequencer: walks the packed tap registers word by word and
// lane by lane, drives the MAC datapath, then returns the accumulated result.
module fir_xifu_seq #(
    parameter int unsigned NB_REGS    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [ID_WIDTH-1:0]           cmd_id_i,
    input  logic [4:0]                    cmd_rd_i,
    input  logic [$clog2(NB_REGS+1)-1:0]  cmd_nregs_i,
    input  logic                          kill_valid_i,
    input  logic [ID_WIDTH-1:0]           kill_id_i,
    output logic                          rf_re_o,
    output logic [$clog2(NB_REGS)-1:0]    rf_raddr_o,
    output logic                          mac_en_o,
    output logic                          mac_clr_o,
    output logic [$clog2(32/DATA_WIDTH)-1:0] mac_sel_o,
    input  logic [31:0]                   acc_i,
    output logic                          res_valid_o,
    input  logic                          res_ready_i,
    output logic [ID_WIDTH-1:0]           res_id_o,
    output logic [4:0]                    res_rd_o,
    output logic [31:0]                   res_data_o,
    output logic                          busy_o
);

    localparam int unsigned TPW = 32 / DATA_WIDTH;
    localparam int unsigned NW  = $clog2(NB_REGS + 1);
    localparam int unsigned AW  = $clog2(NB_REGS);
    localparam int unsigned SW  = $clog2(TPW);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e                state_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic [4:0]            rd_q;
    logic [NW-1:0]         n_q;
    logic [AW-1:0]         w_q;
    logic [SW-1:0]         t_q;
    logic [31:0]           result_q;

    logic                  kill_hit;
    logic                  run_act;
    logic                  last_step;
    logic [NW-1:0]         n_clamp;

    // Requested register count clamped to the number of tap registers
    assign n_clamp = (cmd_nregs_i > NW'(NB_REGS)) ? NW'(NB_REGS) : cmd_nregs_i;

    // A kill only applies to the in-flight instruction it names
    assign kill_hit = kill_valid_i && (kill_id_i == id_q) && (state_q != IDLE);

    // Final lane of the final word in the RUN walk
    assign last_step = (NW'(w_q) == (n_q - NW'(1))) && (t_q == SW'(TPW - 1));

    // RUN step that actually issues (a kill suppresses it in the same cycle)
    assign run_act = (state_q == RUN) && !kill_hit;

    // Sequencer state, counters and latched instruction fields
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            id_q     <= '0;
            rd_q     <= '0;
            n_q      <= '0;
            w_q      <= '0;
            t_q      <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        id_q     <= cmd_id_i;
                        rd_q     <= cmd_rd_i;
                        n_q      <= n_clamp;
                        w_q      <= '0;
                        t_q      <= '0;
                        result_q <= '0;
                        state_q  <= (n_clamp == '0) ? RESP : RUN;
                    end
                end
                RUN: begin
                    if (kill_hit) begin
                        state_q <= IDLE;
                        w_q     <= '0;
                        t_q     <= '0;
                    end else if (last_step) begin
                        state_q <= DRAIN;
                        w_q     <= '0;
                        t_q     <= '0;
                    end else if (t_q == SW'(TPW - 1)) begin
                        t_q <= '0;
                        w_q <= w_q + AW'(1);
                    end else begin
                        t_q <= t_q + SW'(1);
                    end
                end
                DRAIN: begin
                    if (kill_hit) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= acc_i;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    if (kill_hit || res_ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath controls decoded from the state and counter flops
    assign rf_re_o    = run_act;
    assign mac_en_o   = run_act;
    assign mac_clr_o  = run_act && (w_q == '0) && (t_q == '0);
    assign rf_raddr_o = (state_q == RUN) ? w_q : '0;
    assign mac_sel_o  = (state_q == RUN) ? t_q : '0;

    // Handshake and result outputs straight from the flops
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign res_valid_o = (state_q == RESP);
    assign res_id_o    = id_q;
    assign res_rd_o    = rd_q;
    assign res_data_o  = result_q;

endmodule
